pipe_stage_reg: RTL and testbench

Parametrised inter-stage pipeline register for the 5-stage MIPS core. It is the generalised successor of the fixed IF/ID latch, and any stage boundary (IF/ID, ID/EX, EX/MEM, MEM/WB) can instantiate it. The block carries `LANES` data words plus a valid bit. It supports stall, hold, bubble insertion and an explicit flush, and it keeps per-lane bubble masking and saturating stall/bubble performance counters.

---
 rtl/pipe_stage_reg_pkg.sv | 18 +
 rtl/pipe_stage_reg_sat_counter.sv | 26 ++
 rtl/pipe_stage_reg.sv | 106 ++++++++++
 tb/tb_pipe_stage_reg.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/pipe_stage_reg_pkg.sv
// Shared constants and types for the generic inter-stage pipeline register.
package pipe_stage_reg_pkg;

    localparam int unsigned DataWidth = 32;

    localparam logic Stop   = 1'b1;
    localparam logic NoStop = 1'b0;

    localparam int unsigned LANE_PC  = 0;
    localparam int unsigned LANE_INS = 1;

    typedef enum logic [1:0] {
        ACT_HOLD   = 2'd0,
        ACT_LOAD   = 2'd1,
        ACT_BUBBLE = 2'd2
    } action_e;

endpackage

// File: rtl/pipe_stage_reg_sat_counter.sv
// Saturating up-counter with synchronous clear that overrides increment.
module sat_counter #(
    parameter int unsigned W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] q
);

    logic [W-1:0] r_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_q <= '0;
        end else if (clr) begin
            r_q <= '0;
        end else if (inc && (r_q != '1)) begin
            r_q <= r_q + W'(1);
        end
    end

    assign q = r_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Parametrised pipeline stage register: load / hold / bubble / flush with
// per-lane keep masking and saturating stall and bubble counters.
module pipe_stage_reg
    import pipe_stage_reg_pkg::*;
#(
    parameter int unsigned        DATA_W    = DataWidth,
    parameter int unsigned        LANES     = 2,
    parameter int unsigned        STOP_W    = 6,
    parameter int unsigned        STAGE     = 1,
    parameter logic [LANES-1:0]   KEEP_MASK = '0,
    parameter int unsigned        CNT_W     = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [STOP_W-1:0]         stop,
    input  logic                      flush,
    input  logic                      in_valid,
    input  logic [LANES*DATA_W-1:0]   in_data,
    input  logic                      cnt_clr,
    output logic                      out_valid,
    output logic [LANES*DATA_W-1:0]   out_data,
    output logic [CNT_W-1:0]          stall_cnt,
    output logic [CNT_W-1:0]          bubble_cnt
);

    generate
        if (STAGE + 1 >= STOP_W) begin : g_bad_stage
            $error("pipe_stage_reg: STAGE+1 must be below STOP_W");
        end
        if (LANES < 1) begin : g_bad_lanes
            $error("pipe_stage_reg: LANES must be at least 1");
        end
    endgenerate

    logic    w_stall;
    logic    w_down_stall;
    logic    w_stall_bubble;
    action_e w_action;
    logic    r_valid;

    assign w_stall        = (stop[STAGE] == Stop);
    assign w_down_stall   = (stop[STAGE+1] == Stop);
    assign w_stall_bubble = !flush && w_stall && !w_down_stall;

    // Strict-priority action select: flush, stall-bubble, load, hold.
    always_comb begin
        w_action = ACT_HOLD;
        if (flush) begin
            w_action = ACT_BUBBLE;
        end else if (w_stall_bubble) begin
            w_action = ACT_BUBBLE;
        end else if (!w_stall) begin
            w_action = ACT_LOAD;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid <= 1'b0;
        end else begin
            case (w_action)
                ACT_LOAD:   r_valid <= in_valid;
                ACT_BUBBLE: r_valid <= 1'b0;
                default:    r_valid <= r_valid;
            endcase
        end
    end

    assign out_valid = r_valid;

    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
        logic [DATA_W-1:0] r_lane;

        // Kept lanes (e.g. pc) survive a bubble so exceptions stay attributable.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_lane <= '0;
            end else begin
                case (w_action)
                    ACT_LOAD:   r_lane <= in_data[gi*DATA_W +: DATA_W];
                    ACT_BUBBLE: r_lane <= KEEP_MASK[gi] ? r_lane : '0;
                    default:    r_lane <= r_lane;
                endcase
            end
        end

        assign out_data[gi*DATA_W +: DATA_W] = r_lane;
    end

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk (clk),
        .rst (rst),
        .clr (cnt_clr),
        .inc (w_stall),
        .q   (stall_cnt)
    );

    sat_counter #(.W(CNT_W)) u_bubble_cnt (
        .clk (clk),
        .rst (rst),
        .clr (cnt_clr),
        .inc (w_stall_bubble),
        .q   (bubble_cnt)
    );

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench for pipe_stage_reg (STAGE=1, KEEP_MASK=01, 4-bit counters).
module tb_pipe_stage_reg;

    logic        clk;
    logic        rst;
    logic [5:0]  stop;
    logic        flush;
    logic        in_valid;
    logic [63:0] in_data;
    logic        cnt_clr;
    logic        out_valid;
    logic [63:0] out_data;
    logic [3:0]  stall_cnt;
    logic [3:0]  bubble_cnt;

    int total = 0;
    int bad   = 0;

    pipe_stage_reg #(
        .DATA_W    (32),
        .LANES     (2),
        .STOP_W    (6),
        .STAGE     (1),
        .KEEP_MASK (2'b01),
        .CNT_W     (4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .stop       (stop),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .cnt_clr    (cnt_clr),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .stall_cnt  (stall_cnt),
        .bubble_cnt (bubble_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic v, input logic [63:0] d,
                           input logic [3:0] sc, input logic [3:0] bc);
        chk({tag, ".valid"}, {63'd0, out_valid}, {63'd0, v});
        chk({tag, ".data"}, out_data, d);
        chk({tag, ".stall"}, {60'd0, stall_cnt}, {60'd0, sc});
        chk({tag, ".bubble"}, {60'd0, bubble_cnt}, {60'd0, bc});
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst      = 1'b1;
        stop     = 6'b000000;
        flush    = 1'b0;
        in_valid = 1'b0;
        in_data  = '0;
        cnt_clr  = 1'b0;
        step();
        step();
        chk_all("reset", 1'b0, 64'h0, 4'd0, 4'd0);
        @(negedge clk);
        rst = 1'b0;

        // load
        in_data  = {32'h2402_0005, 32'h0040_0000};
        in_valid = 1'b1;
        step();
        chk_all("load", 1'b1, 64'h2402_0005_0040_0000, 4'd0, 4'd0);

        // hold for 3 cycles, upstream keeps changing
        stop    = 6'b000110;
        in_data = 64'hDEAD_BEEF_CAFE_F00D;
        step();
        step();
        step();
        chk_all("hold", 1'b1, 64'h2402_0005_0040_0000, 4'd3, 4'd0);

        // stall bubble keeps pc lane, zeros ins lane
        stop = 6'b000010;
        step();
        chk_all("bubble1", 1'b0, 64'h0000_0000_0040_0000, 4'd4, 4'd1);
        step();
        chk_all("bubble2", 1'b0, 64'h0000_0000_0040_0000, 4'd5, 4'd2);

        // lanes load even with in_valid low
        stop     = 6'b000000;
        in_valid = 1'b0;
        in_data  = {32'hAAAA_0001, 32'h0000_1000};
        step();
        chk_all("load_inv", 1'b0, 64'hAAAA_0001_0000_1000, 4'd5, 4'd2);

        // upstream-only stall bit does not affect this stage
        stop     = 6'b000001;
        in_valid = 1'b1;
        in_data  = {32'h1111_2222, 32'h3333_4444};
        step();
        chk_all("load_up", 1'b1, 64'h1111_2222_3333_4444, 4'd5, 4'd2);

        // downstream stall alone still loads
        stop    = 6'b000100;
        in_data = {32'h5555_6666, 32'h7777_8888};
        step();
        chk_all("load_dn", 1'b1, 64'h5555_6666_7777_8888, 4'd5, 4'd2);

        // flush beats hold; stall counted, bubble not
        stop  = 6'b000110;
        flush = 1'b1;
        step();
        chk_all("flush_hold", 1'b0, 64'h0000_0000_7777_8888, 4'd6, 4'd2);

        // flush on a would-be stall bubble is still not a counted bubble
        stop = 6'b000010;
        step();
        chk_all("flush_rule2", 1'b0, 64'h0000_0000_7777_8888, 4'd7, 4'd2);

        // saturation
        flush = 1'b0;
        stop  = 6'b000110;
        for (int i = 0; i < 20; i++) step();
        chk_all("saturate", 1'b0, 64'h0000_0000_7777_8888, 4'd15, 4'd2);

        // clear beats increment
        cnt_clr = 1'b1;
        step();
        chk_all("clear", 1'b0, 64'h0000_0000_7777_8888, 4'd0, 4'd0);
        cnt_clr = 1'b0;
        step();
        chk_all("after_clr", 1'b0, 64'h0000_0000_7777_8888, 4'd1, 4'd0);

        // async reset mid-stall discards held word
        stop     = 6'b000000;
        in_valid = 1'b1;
        in_data  = 64'h0040_0004_2402_0001;
        step();
        chk_all("pre_rst", 1'b1, 64'h0040_0004_2402_0001, 4'd1, 4'd0);
        stop = 6'b000110;
        step();
        chk_all("pre_rst_hold", 1'b1, 64'h0040_0004_2402_0001, 4'd2, 4'd0);
        #2;
        rst = 1'b1;
        #1;
        chk_all("async_rst", 1'b0, 64'h0, 4'd0, 4'd0);
        @(negedge clk);
        rst      = 1'b0;
        stop     = 6'b000000;
        in_valid = 1'b1;
        in_data  = {32'h2402_0007, 32'h0040_0008};
        step();
        chk_all("post_rst", 1'b1, 64'h2402_0007_0040_0008, 4'd0, 4'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
